// File: rtl/pal_pkg.sv
// Shared PAL definitions: loader state encoding and configuration bitstream geometry.
package pal_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWaitByte,
      StShift,
      StWaitChk,
      StDone,
      StErr
   } state_e;

   // Chain length: two AND-plane bits per input per product term, one OR-plane bit per term/output.
   function automatic int unsigned bitstream_len(input int unsigned num_inputs,
                                                 input int unsigned num_outputs,
                                                 input int unsigned num_interm_stages);
      return 2 * num_inputs * num_interm_stages + num_interm_stages * num_outputs;
   endfunction

endpackage

// File: rtl/pal_cfg_loader_if.sv
// Byte-stream valid/ready channel feeding the PAL configuration loader.
interface pal_cfg_loader_if;
   logic [7:0] byte_in;
   logic       byte_valid;
   logic       byte_ready;

   modport master (output byte_in, output byte_valid, input byte_ready);
   modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/pal_cfg_shifter.sv
// 8-bit parallel-load, right-shift register; bit 0 is the serial output.
module pal_cfg_shifter (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_i,
   input  logic       shift_i,
   input  logic [7:0] data_i,
   output logic       bit_o
);

   logic [7:0] shreg_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_q <= '0;
      end else if (load_i) begin
         shreg_q <= data_i;
      end else if (shift_i) begin
         shreg_q <= {1'b0, shreg_q[7:1]};
      end
   end

   assign bit_o = shreg_q[0];

endmodule

// File: rtl/pal_cfg_loader.sv
// PAL configuration sequencer: accepts bitstream bytes, shifts them LSB-first into the
// config chain, verifies an XOR trailer and only then enables the PAL.
module pal_cfg_loader
   import pal_pkg::*;
#(
   parameter int unsigned NUM_INPUTS        = 8,
   parameter int unsigned NUM_OUTPUTS       = 8,
   parameter int unsigned NUM_INTERM_STAGES = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   pal_cfg_loader_if.slave        byte_if,
   output logic                   cfg_data,
   output logic                   cfg_shift,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic                   pal_enable
);

   localparam int unsigned BITSTREAM_LEN =
      bitstream_len(NUM_INPUTS, NUM_OUTPUTS, NUM_INTERM_STAGES);
   localparam int unsigned CNT_W = $clog2(BITSTREAM_LEN + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITSTREAM_LEN - 1);

   state_e           state_q;
   logic [CNT_W-1:0] bit_cnt_q;
   logic [7:0]       chk_q;
   logic             byte_ready_q;
   logic             cfg_shift_q;
   logic             busy_q;
   logic             done_q;
   logic             err_q;
   logic             pal_enable_q;

   logic accept;
   logic load_en;
   logic shift_en;

   assign accept   = byte_ready_q & byte_if.byte_valid;
   assign load_en  = (state_q == StWaitByte) & accept;
   assign shift_en = (state_q == StShift);

   pal_cfg_shifter u_shifter (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load_en),
      .shift_i (shift_en),
      .data_i  (byte_if.byte_in),
      .bit_o   (cfg_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         bit_cnt_q    <= '0;
         chk_q        <= '0;
         byte_ready_q <= 1'b0;
         cfg_shift_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         pal_enable_q <= 1'b0;
      end else begin
         unique case (state_q)
            // start is only honoured outside a load, so a reload can never interleave
            StIdle, StDone, StErr: begin
               if (start) begin
                  state_q      <= StWaitByte;
                  byte_ready_q <= 1'b1;
                  busy_q       <= 1'b1;
                  done_q       <= 1'b0;
                  err_q        <= 1'b0;
                  pal_enable_q <= 1'b0;
                  bit_cnt_q    <= '0;
                  chk_q        <= '0;
               end
            end
            StWaitByte: begin
               if (accept) begin
                  state_q      <= StShift;
                  chk_q        <= chk_q ^ byte_if.byte_in;
                  byte_ready_q <= 1'b0;
                  cfg_shift_q  <= 1'b1;
               end
            end
            StShift: begin
               bit_cnt_q <= bit_cnt_q + 1'b1;
               // A short final byte ends on LAST_BIT before its 8th bit
               if (bit_cnt_q == LAST_BIT) begin
                  state_q      <= StWaitChk;
                  cfg_shift_q  <= 1'b0;
                  byte_ready_q <= 1'b1;
               end else if (bit_cnt_q[2:0] == 3'd7) begin
                  state_q      <= StWaitByte;
                  cfg_shift_q  <= 1'b0;
                  byte_ready_q <= 1'b1;
               end
            end
            StWaitChk: begin
               if (accept) begin
                  byte_ready_q <= 1'b0;
                  busy_q       <= 1'b0;
                  if (byte_if.byte_in == chk_q) begin
                     state_q      <= StDone;
                     done_q       <= 1'b1;
                     pal_enable_q <= 1'b1;
                  end else begin
                     state_q <= StErr;
                     err_q   <= 1'b1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign byte_if.byte_ready = byte_ready_q;
   assign cfg_shift          = cfg_shift_q;
   assign busy               = busy_q;
   assign done               = done_q;
   assign err                = err_q;
   assign pal_enable         = pal_enable_q;

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Randomized self-checking bench for pal_cfg_loader against a transaction-level model.
module tb_pal_cfg_loader;

   localparam int LEN    = 192;
   localparam int NBYTES = 24;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic cfg_data, cfg_shift, busy, done, err, pal_enable;

   pal_cfg_loader_if byte_if ();

   pal_cfg_loader #(
      .NUM_INPUTS        (8),
      .NUM_OUTPUTS       (8),
      .NUM_INTERM_STAGES (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .byte_if    (byte_if),
      .cfg_data   (cfg_data),
      .cfg_shift  (cfg_shift),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .pal_enable (pal_enable)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: a load is a list of byte transactions; each accepted data byte owes
   // min(8, bits left) shift cycles, and its bits join a queue of expected chain bits.
   bit         m_active, m_done, m_err;
   int         m_shift_rem, m_bits_left;
   logic [7:0] m_chk;
   bit         m_q[$];

   always @(posedge clk) begin
      int n;
      if (rst) begin
         m_active = 0; m_done = 0; m_err = 0;
         m_shift_rem = 0; m_bits_left = 0; m_chk = 8'h00;
         m_q.delete();
      end else if (!m_active) begin
         if (start) begin
            m_active = 1; m_done = 0; m_err = 0;
            m_bits_left = LEN; m_chk = 8'h00; m_shift_rem = 0;
         end
      end else if (m_shift_rem > 0) begin
         m_shift_rem--;
      end else if (byte_if.byte_valid) begin
         if (m_bits_left > 0) begin
            n = (m_bits_left < 8) ? m_bits_left : 8;
            for (int i = 0; i < n; i++) m_q.push_back(byte_if.byte_in[i]);
            m_shift_rem = n;
            m_bits_left -= n;
            m_chk ^= byte_if.byte_in;
         end else begin
            m_active = 0;
            m_done   = (byte_if.byte_in == m_chk);
            m_err    = !m_done;
         end
      end
   end

   int shift_cnt = 0;
   bit cap[$];
   bit cmp_en = 0;

   always @(negedge clk) begin
      if (cmp_en) begin
         check("busy", busy, m_active);
         check("byte_ready", byte_if.byte_ready, (m_active && m_shift_rem == 0) ? 1 : 0);
         check("cfg_shift", cfg_shift, (m_shift_rem > 0) ? 1 : 0);
         check("done", done, m_done);
         check("err", err, m_err);
         check("pal_enable", pal_enable, m_done);
         if (cfg_shift) begin
            shift_cnt++;
            cap.push_back(cfg_data);
            check("cfg_data_expected", (m_q.size() != 0) ? 1 : 0, 1);
            if (m_q.size() != 0) check("cfg_data", cfg_data, m_q.pop_front());
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      byte_if.byte_in    = b;
      byte_if.byte_valid = 1'b1;
      while (!byte_if.byte_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("byte_ready_seen", byte_if.byte_ready, 1);
      @(negedge clk);
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic idle(input int cycles);
      byte_if.byte_valid = 1'b0;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic load(input logic [7:0] data[NBYTES], input logic [7:0] trailer,
                       input int stall_after, input bit rand_gaps);
      int n;
      for (int i = 0; i < NBYTES; i++) begin
         if (rand_gaps && $urandom_range(3) == 0) idle($urandom_range(5, 1));
         send_byte(data[i]);
         if (i == stall_after) begin
            byte_if.byte_valid = 1'b0;
            n = 0;
            while (!byte_if.byte_ready && n < 20) begin
               @(negedge clk);
               n++;
            end
            for (int k = 0; k < 20; k++) begin
               check("stall_no_shift", cfg_shift, 0);
               @(negedge clk);
            end
         end
      end
      send_byte(trailer);
      byte_if.byte_valid = 1'b0;
   endtask

   logic [7:0] data[NBYTES];
   logic [7:0] xsum;
   bit         ref_bits[LEN];
   int         base;
   int         diffs;
   int         exp8[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
   bit         good;

   initial begin
      rst = 1'b1; start = 1'b0;
      byte_if.byte_valid = 1'b0; byte_if.byte_in = 8'h00;
      repeat (2) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_byte_ready", byte_if.byte_ready, 0);
      check("reset_cfg_shift", cfg_shift, 0);
      check("reset_cfg_data", cfg_data, 0);
      check("reset_done", done, 0);
      check("reset_err", err, 0);
      check("reset_pal_enable", pal_enable, 0);
      rst = 1'b0;
      cmp_en = 1;
      @(negedge clk);
      do_start();
      check("start_byte_ready", byte_if.byte_ready, 1);

      // Ordering: 0xA5 then zeros, trailer 0xA5
      for (int i = 0; i < NBYTES; i++) data[i] = 8'h00;
      data[0] = 8'hA5;
      base = shift_cnt;
      load(data, 8'hA5, -1, 0);
      check("order_done", done, 1);
      check("order_pal_enable", pal_enable, 1);
      check("order_shift_count", shift_cnt - base, LEN);
      for (int i = 0; i < 8; i++) check($sformatf("order_bit%0d", i), cap[base + i], exp8[i]);

      // Bad checksum
      do_start();
      for (int i = 0; i < NBYTES; i++) data[i] = 8'h00;
      load(data, 8'h01, -1, 0);
      check("badchk_err", err, 1);
      check("badchk_done", done, 0);
      check("badchk_pal_enable", pal_enable, 0);

      // Stall: same random stream with and without a gap after byte 5
      xsum = 8'h00;
      for (int i = 0; i < NBYTES; i++) begin
         data[i] = 8'($urandom);
         xsum ^= data[i];
      end
      do_start();
      base = shift_cnt;
      load(data, xsum, -1, 0);
      for (int i = 0; i < LEN; i++) ref_bits[i] = cap[base + i];
      check("nostall_done", done, 1);
      do_start();
      base = shift_cnt;
      load(data, xsum, 5, 0);
      check("stall_shift_count", shift_cnt - base, LEN);
      diffs = 0;
      for (int i = 0; i < LEN; i++) if (cap[base + i] != ref_bits[i]) diffs++;
      check("stall_bits_differ", diffs, 0);
      check("stall_done", done, 1);

      // Random streams with random valid gaps and a random trailer error
      for (int r = 0; r < 4; r++) begin
         xsum = 8'h00;
         for (int i = 0; i < NBYTES; i++) begin
            data[i] = 8'($urandom);
            xsum ^= data[i];
         end
         good = $urandom_range(1);
         do_start();
         load(data, good ? xsum : (xsum ^ 8'($urandom_range(255, 1))), -1, 1);
         check("rand_done", done, good);
         check("rand_err", err, !good);
      end

      // Start ignored mid-load, then reset at bit 100
      do_start();
      for (int i = 0; i < 3; i++) send_byte(data[i]);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_ignored_busy", busy, 1);
      for (int i = 3; i < 13; i++) send_byte(data[i]);
      byte_if.byte_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_pal_enable", pal_enable, 0);
      check("abort_busy", busy, 0);
      check("abort_byte_ready", byte_if.byte_ready, 0);
      do_start();
      load(data, xsum, -1, 0);
      check("after_abort_done", done, 1);

      // Reload from DONE
      do_start();
      check("reload_done_clear", done, 0);
      check("reload_pal_enable_clear", pal_enable, 0);
      load(data, xsum, -1, 0);
      check("reload_done", done, 1);
      check("reload_pal_enable", pal_enable, 1);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
